aes_key_expand: RTL and testbench

- Iterative AES key-schedule generator that sits directly upstream of the AES cipher core.
- Takes a cipher key of Nk words and produces all Nr+1 round keys, `k_sch[0:Nr]`, one 32-bit schedule word per clock.
- Asserts `valid` once the schedule is complete and stable. The cipher's `load` is gated by this `valid`.
- Supports AES-128, AES-192 and AES-256 through the Nk parameter.

---
 rtl/aes_key_expand.sv | 160 ++++++++++++++++
 tb/tb_aes_key_expand.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128/192/256 key schedule.
// Produces one 32-bit schedule word per clock and holds all Nr+1 round keys
// in registers. valid is a level that stays high until the next start.
module aes_key_expand #(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = Nk + 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [Nk*32-1:0] key,
  output logic           busy,
  output logic           valid,
  output logic [127:0]   k_sch [0:Nr]
);

  localparam int unsigned KW = Nk * 32;
  localparam int unsigned NW = 4 * (Nr + 1);
  localparam int unsigned SW = NW * 32;
  localparam int unsigned IW = $clog2(NW + 1);
  localparam int unsigned PW = $clog2(Nk);
  localparam bit          HAS_SUB4 = (Nk == 8);

  // AES S-box; entry x lives at index ~x so entry 0 is the leftmost literal byte.
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[~x];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      r[8*j +: 8] = sbox(w[8*j +: 8]);
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            load_c, step_c;
  logic [IW-1:0]   idx_q;
  logic [PW-1:0]   phase_q;
  logic [7:0]      rcon_q;
  logic [KW-1:0]   win_q;
  logic [SW-1:0]   words_q;

  logic [31:0]     prev_w, old_w, rot_w, sub_w, temp_w, new_w;
  logic [7:0]      rcon_nxt;
  logic [PW-1:0]   phase_nxt;

  // State and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  // Next state: start is honoured only when idle or done; the last word ends EXPAND.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load_c  = 1'b1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        step_c = 1'b1;
        if (idx_q == IW'(NW - 1)) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next schedule word from the sliding window w[i-Nk..i-1].
  always_comb begin
    prev_w    = win_q[KW-1 -: 32];
    old_w     = win_q[31:0];
    rot_w     = {prev_w[7:0], prev_w[31:8]};
    sub_w     = sub_word((phase_q == '0) ? rot_w : prev_w);
    rcon_nxt  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    phase_nxt = (phase_q == PW'(Nk - 1)) ? '0 : PW'(phase_q + 1'b1);
    if (phase_q == '0) begin
      temp_w = sub_w ^ {24'h0, rcon_q};
    end else if (HAS_SUB4 && (phase_q == PW'(Nk / 2))) begin
      temp_w = sub_w;
    end else begin
      temp_w = prev_w;
    end
    new_w = old_w ^ temp_w;
  end

  // Schedule storage, word index, mod-Nk phase and Rcon.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      phase_q <= '0;
      rcon_q  <= 8'h01;
      win_q   <= '0;
      words_q <= '0;
    end else if (load_c) begin
      idx_q            <= IW'(Nk);
      phase_q          <= '0;
      rcon_q           <= 8'h01;
      win_q            <= key;
      words_q[KW-1:0]  <= key;
    end else if (step_c) begin
      words_q[{idx_q, 5'd0} +: 32] <= new_w;
      win_q   <= {new_w, win_q[KW-1:32]};
      idx_q   <= IW'(idx_q + 1'b1);
      phase_q <= phase_nxt;
      if (phase_q == '0) begin
        rcon_q <= rcon_nxt;
      end
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;

  for (genvar r = 0; r <= Nr; r++) begin : g_ksch
    assign k_sch[r] = words_q[128*r +: 128];
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: checks the key schedule for Nk=4/6/8 against a
// GF(2^8)-based reference model, plus FIPS-197 vectors and control corners.
module tb_aes_key_expand;

  logic         clk;
  logic         rst;
  logic         start4, start6, start8;
  logic [255:0] key_r;
  logic         busy4, busy6, busy8;
  logic         valid4, valid6, valid8;
  logic [127:0] ks4 [0:10];
  logic [127:0] ks6 [0:12];
  logic [127:0] ks8 [0:14];

  int           total;
  int           bad;
  logic [7:0]   sb [256];
  logic [31:0]  exp_w [60];

  aes_key_expand #(.Nk(4)) u_k4 (
    .clk(clk), .rst(rst), .start(start4), .key(key_r[127:0]),
    .busy(busy4), .valid(valid4), .k_sch(ks4)
  );
  aes_key_expand #(.Nk(6)) u_k6 (
    .clk(clk), .rst(rst), .start(start6), .key(key_r[191:0]),
    .busy(busy6), .valid(valid6), .k_sch(ks6)
  );
  aes_key_expand #(.Nk(8)) u_k8 (
    .clk(clk), .rst(rst), .start(start8), .key(key_r),
    .busy(busy8), .valid(valid8), .k_sch(ks8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? (8'(aa << 1) ^ 8'h1b) : 8'(aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] m_sub(input logic [31:0] x);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = sb[x[8*j +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] m_rot(input logic [31:0] x);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = x[8*((j + 1) % 4) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] m_rcon(input int n);
    logic [7:0] rc;
    rc = 8'h01;
    for (int m = 1; m < n; m++) rc = gmul(rc, 8'h02);
    return rc;
  endfunction

  task automatic ref_sched(input int nk, input logic [255:0] k);
    logic [31:0] t;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        exp_w[i] = k[32*i +: 32];
      end else begin
        t = exp_w[i-1];
        if (i % nk == 0) begin
          t = m_sub(m_rot(t));
          t[7:0] = t[7:0] ^ m_rcon(i / nk);
        end else if (nk == 8 && i % nk == 4) begin
          t = m_sub(t);
        end
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
  endtask

  // ---------------- DUT views ----------------
  function automatic logic get_valid(input int nk);
    case (nk)
      4:       return valid4;
      6:       return valid6;
      default: return valid8;
    endcase
  endfunction

  function automatic logic get_busy(input int nk);
    case (nk)
      4:       return busy4;
      6:       return busy6;
      default: return busy8;
    endcase
  endfunction

  function automatic logic [127:0] get_rk(input int nk, input int r);
    logic [3:0] ri;
    ri = 4'(r);
    case (nk)
      4:       return ks4[ri];
      6:       return ks6[ri];
      default: return ks8[ri];
    endcase
  endfunction

  task automatic set_start(input int nk, input logic v);
    case (nk)
      4:       start4 = v;
      6:       start6 = v;
      default: start8 = v;
    endcase
  endtask

  // Start pulse; returns at the falling edge right after the sampling edge.
  task automatic pulse_start(input int nk);
    @(negedge clk);
    set_start(nk, 1'b1);
    @(negedge clk);
    set_start(nk, 1'b0);
  endtask

  task automatic wait_valid(input int nk, output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    while (!get_valid(nk) && cyc < 200) begin
      if (get_busy(nk)) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_sched(input int nk, input logic [255:0] k, input string tag);
    ref_sched(nk, k);
    for (int r = 0; r <= nk + 6; r++) begin
      check($sformatf("%s rk%0d", tag, r), 256'(get_rk(nk, r)),
            256'({exp_w[4*r+3], exp_w[4*r+2], exp_w[4*r+1], exp_w[4*r]}));
    end
  endtask

  task automatic run_full(input int nk, input logic [255:0] k, input int lat, input string tag);
    int cyc, bcnt;
    key_r = k;
    pulse_start(nk);
    wait_valid(nk, cyc, bcnt);
    check({tag, " latency"}, 256'(cyc), 256'(lat));
    check({tag, " busy cycles"}, 256'(bcnt), 256'(lat));
    check({tag, " busy low"}, 256'(get_busy(nk)), 256'(0));
    repeat (3) @(negedge clk);
    check({tag, " valid held"}, 256'(get_valid(nk)), 256'(1));
    check_sched(nk, k, tag);
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    return k;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] ka, kb, kc;
    logic [191:0] a2;
    int cyc, bcnt;
    total = 0;
    bad = 0;
    rst = 1'b1;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key_r = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    check("reset busy", 256'(busy4), 256'(0));
    check("reset valid", 256'({valid4, valid6, valid8}), 256'(0));
    check("reset ks4[0]", 256'(ks4[0]), 256'(0));
    check("reset ks8[14]", 256'(ks8[14]), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 A.1
    ka = 256'(128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b);
    run_full(4, ka, 40, "A1");
    check("A1 rk0 key", 256'(ks4[0]), ka);
    check("A1 w4", 256'(ks4[1][31:0]), 256'(32'h17fefaa0));
    check("A1 rk10", 256'(ks4[10]), 256'(128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0));

    // FIPS-197 C.3
    for (int n = 0; n < 32; n++) kb[8*n +: 8] = 8'(n);
    run_full(8, kb, 52, "C3");
    check("C3 rk14", 256'(ks8[14]), 256'(128'h36de686d_3cc21a37_e97909bf_cc79fc24));

    // FIPS-197 A.2
    a2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    kc = '0;
    for (int n = 0; n < 24; n++) kc[8*n +: 8] = a2[8*(23-n) +: 8];
    run_full(6, kc, 46, "A2");

    // Random keys for every key size
    for (int t = 0; t < 3; t++) begin
      run_full(4, rand_key(), 40, $sformatf("rnd4_%0d", t));
      run_full(6, rand_key(), 46, $sformatf("rnd6_%0d", t));
      run_full(8, rand_key(), 52, $sformatf("rnd8_%0d", t));
    end

    // start during EXPAND is ignored and the key is not resampled
    ka = rand_key();
    kb = rand_key();
    key_r = ka;
    pulse_start(4);
    repeat (9) @(negedge clk);
    key_r = kb;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("busy restart busy", 256'(busy4), 256'(1));
    wait_valid(4, cyc, bcnt);
    check("busy restart latency", 256'(cyc + 10), 256'(40));
    check_sched(4, ka, "busy restart");

    // start in DONE restarts with the new key
    kc = rand_key();
    @(negedge clk);
    key_r = kc;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("done restart valid fell", 256'(valid4), 256'(0));
    key_r = ka;
    wait_valid(4, cyc, bcnt);
    check("done restart latency", 256'(cyc), 256'(40));
    check_sched(4, kc, "done restart");

    // reset mid-expansion clears state asynchronously
    key_r = rand_key();
    pulse_start(4);
    repeat (19) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid rst busy", 256'(busy4), 256'(0));
    check("mid rst valid", 256'(valid4), 256'(0));
    check("mid rst rk0", 256'(ks4[0]), 256'(0));
    check("mid rst rk4", 256'(ks4[4]), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    run_full(4, rand_key(), 40, "post rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
